baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_tick_gen.sv | 96 +++++++++
 tb/tb_baud_tick_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: emits oversample, bit-centre and bit-end
// pulses from a D + F/2^FRAC_W clock divisor with drift-free accumulation.
module baud_tick_gen #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int RST_DIV_INT  = 54,
    parameter int RST_DIV_FRAC = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    sync_clr,
    output logic                    ovs_tick,
    output logic                    mid_tick,
    output logic                    bit_tick,
    output logic [$clog2(OVS)-1:0]  ovs_cnt,
    output logic                    cfg_err
);

    localparam int OC_W = $clog2(OVS);
    localparam logic [OC_W-1:0]  OVS_LAST = OC_W'(OVS - 1);
    localparam logic [OC_W-1:0]  MID_LAST = OC_W'(OVS / 2 - 1);
    localparam logic [OC_W-1:0]  OC_ONE   = OC_W'(1);
    localparam logic [DIV_W:0]   CNT_ONE  = (DIV_W + 1)'(1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

    logic [DIV_W-1:0]  div_q;
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] acc;
    logic [DIV_W:0]    cnt;
    logic [FRAC_W:0]   acc_sum;
    logic              carry;
    logic [DIV_W:0]    last_cnt;
    logic              wrap;
    logic              load_ok;

    assign acc_sum = {1'b0, acc} + {1'b0, frac_q};
    assign carry   = acc_sum[FRAC_W];

    // Interval length is div_q + carry; the extra bit keeps 2^DIV_W-1 + 1 exact.
    assign last_cnt = {1'b0, div_q} + {{DIV_W{1'b0}}, carry} - CNT_ONE;
    assign wrap     = (cnt == last_cnt);
    assign load_ok  = load && (div_int >= DIV_MIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= DIV_W'(RST_DIV_INT);
            frac_q   <= FRAC_W'(RST_DIV_FRAC);
            cnt      <= '0;
            acc      <= '0;
            ovs_cnt  <= '0;
            ovs_tick <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            ovs_tick <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            if (load_ok) begin
                div_q   <= div_int;
                frac_q  <= div_frac;
                cnt     <= '0;
                acc     <= '0;
                ovs_cnt <= '0;
                cfg_err <= 1'b0;
            end else begin
                // A rejected load only flags; a concurrent resync still applies.
                if (load) begin
                    cfg_err <= 1'b1;
                end
                if (sync_clr) begin
                    cnt     <= '0;
                    acc     <= '0;
                    ovs_cnt <= '0;
                end else if (enable) begin
                    if (wrap) begin
                        cnt      <= '0;
                        acc      <= acc_sum[FRAC_W-1:0];
                        ovs_tick <= 1'b1;
                        mid_tick <= (ovs_cnt == MID_LAST);
                        bit_tick <= (ovs_cnt == OVS_LAST);
                        ovs_cnt  <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OC_ONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: fixed vector table, directed corner
// sequences and randomized traffic against a closed-form timing model.
module tb_baud_tick_gen;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        sync_clr;
    logic        ovs_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic [3:0]  ovs_cnt;
    logic        cfg_err;

    // Narrow instance exercising the full-width interval (D = 2^4-1 with carry).
    logic        s_en;
    logic        s_ld;
    logic [3:0]  s_d;
    logic [1:0]  s_f;
    logic        s_sc;
    logic        s_ovs;
    logic        s_mid;
    logic        s_bit;
    logic [1:0]  s_cnt;
    logic        s_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: enabled edges since restart and next tick index.
    longint m_d, m_f, m_e, m_k;
    logic       m_ovs, m_mid, m_bit, m_err;
    logic [3:0] m_cnt;

    baud_tick_gen dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .div_int(div_int), .div_frac(div_frac), .sync_clr(sync_clr),
        .ovs_tick(ovs_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
        .ovs_cnt(ovs_cnt), .cfg_err(cfg_err)
    );

    baud_tick_gen #(
        .DIV_W(4), .FRAC_W(2), .OVS(4), .RST_DIV_INT(15), .RST_DIV_FRAC(3)
    ) u_small (
        .clk(clk), .reset_n(reset_n), .enable(s_en), .load(s_ld),
        .div_int(s_d), .div_frac(s_f), .sync_clr(s_sc),
        .ovs_tick(s_ovs), .mid_tick(s_mid), .bit_tick(s_bit),
        .ovs_cnt(s_cnt), .cfg_err(s_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_d = 54; m_f = 4; m_e = 0; m_k = 1;
        m_ovs = 0; m_mid = 0; m_bit = 0; m_cnt = 0; m_err = 0;
    endtask

    // Tick k lands on enabled edge k*D + floor(k*F/16) after a restart.
    task automatic model_edge();
        m_ovs = 0; m_mid = 0; m_bit = 0;
        if (load && div_int >= 2) begin
            m_d = longint'(div_int); m_f = longint'(div_frac);
            m_e = 0; m_k = 1; m_cnt = 0; m_err = 0;
        end else begin
            if (load) m_err = 1;
            if (sync_clr) begin
                m_e = 0; m_k = 1; m_cnt = 0;
            end else if (enable) begin
                m_e++;
                if (m_e == m_k * m_d + ((m_k * m_f) >> 4)) begin
                    m_ovs = 1;
                    m_cnt = 4'(m_k % 16);
                    m_mid = ((m_k % 16) == 8);
                    m_bit = ((m_k % 16) == 0);
                    m_k++;
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic ld, input logic [15:0] d,
                        input logic [3:0] f, input logic sc);
        @(negedge clk);
        enable = en; load = ld; div_int = d; div_frac = f; sync_clr = sc;
        @(posedge clk);
        model_edge();
        #1;
        check("model", {ovs_tick, mid_tick, bit_tick, ovs_cnt, cfg_err},
              {m_ovs, m_mid, m_bit, m_cnt, m_err});
    endtask

    task automatic default_timing(input string tag);
        int t_ovs[4];
        int s_t[4];
        int n_ovs = 0;
        int n_s = 0;
        int t_mid = -1, t_bit = -1, s_mid_t = -1, s_bit_t = -1;
        int exp_ovs[4];
        int exp_s[4];
        exp_ovs = '{54, 108, 162, 217};
        exp_s   = '{15, 31, 47, 63};
        for (int j = 0; j < 4; j++) begin
            t_ovs[j] = -1;
            s_t[j] = -1;
        end
        for (int i = 1; i <= 900; i++) begin
            step(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
            if (ovs_tick && n_ovs < 4) begin t_ovs[n_ovs] = i; n_ovs++; end
            if (mid_tick && t_mid < 0) t_mid = i;
            if (bit_tick && t_bit < 0) t_bit = i;
            if (s_ovs && n_s < 4) begin s_t[n_s] = i; n_s++; end
            if (s_mid && s_mid_t < 0) s_mid_t = i;
            if (s_bit && s_bit_t < 0) s_bit_t = i;
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s ovs_tick#%0d edge", tag, j + 1), 64'(t_ovs[j]), 64'(exp_ovs[j]));
            check($sformatf("%s small ovs_tick#%0d edge", tag, j + 1), 64'(s_t[j]), 64'(exp_s[j]));
        end
        check({tag, " first mid_tick edge"}, 64'(t_mid), 64'd434);
        check({tag, " first bit_tick edge"}, 64'(t_bit), 64'd868);
        check({tag, " small mid_tick edge"}, 64'(s_mid_t), 64'd31);
        check({tag, " small bit_tick edge"}, 64'(s_bit_t), 64'd63);
    endtask

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  f;
        logic        sc;
        logic        e_ovs;
        logic        e_mid;
        logic        e_bit;
        logic [3:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int first_tick;
        int tick_cnt_val;
        int mid_at;
        int tick_at;

        //           en ld  d       f     sc  ovs mid bit cnt   err
        vecs[0]  = '{1, 1, 16'd2, 4'd0, 0,  0,  0,  0, 4'd0, 0};
        vecs[1]  = '{1, 0, 16'd0, 4'd0, 0,  0,  0,  0, 4'd0, 0};
        vecs[2]  = '{1, 0, 16'd0, 4'd0, 0,  1,  0,  0, 4'd1, 0};
        vecs[3]  = '{1, 0, 16'd0, 4'd0, 0,  0,  0,  0, 4'd1, 0};
        vecs[4]  = '{1, 0, 16'd0, 4'd0, 0,  1,  0,  0, 4'd2, 0};
        vecs[5]  = '{0, 0, 16'd0, 4'd0, 0,  0,  0,  0, 4'd2, 0};
        vecs[6]  = '{1, 1, 16'd1, 4'd0, 0,  0,  0,  0, 4'd2, 1};
        vecs[7]  = '{1, 0, 16'd0, 4'd0, 0,  1,  0,  0, 4'd3, 1};
        vecs[8]  = '{1, 1, 16'd0, 4'd0, 1,  0,  0,  0, 4'd0, 1};
        vecs[9]  = '{1, 0, 16'd0, 4'd0, 0,  0,  0,  0, 4'd0, 1};
        vecs[10] = '{1, 0, 16'd0, 4'd0, 0,  1,  0,  0, 4'd1, 1};
        vecs[11] = '{1, 1, 16'd3, 4'd0, 1,  0,  0,  0, 4'd0, 0};
        vecs[12] = '{1, 0, 16'd0, 4'd0, 0,  0,  0,  0, 4'd0, 0};
        vecs[13] = '{1, 0, 16'd0, 4'd0, 0,  0,  0,  0, 4'd0, 0};
        vecs[14] = '{1, 0, 16'd0, 4'd0, 0,  1,  0,  0, 4'd1, 0};

        reset_n = 1'b0; enable = 1'b0; load = 1'b0; div_int = '0; div_frac = '0; sync_clr = 1'b0;
        s_en = 1'b1; s_ld = 1'b0; s_d = '0; s_f = '0; s_sc = 1'b0;
        model_reset();
        #22;
        check("reset outputs", {ovs_tick, mid_tick, bit_tick, ovs_cnt, cfg_err}, 64'd0);
        @(posedge clk); #3 reset_n = 1'b1;

        default_timing("defaults");

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].en, vecs[i].ld, vecs[i].d, vecs[i].f, vecs[i].sc);
            check($sformatf("table vec%0d", i), {ovs_tick, mid_tick, bit_tick, ovs_cnt, cfg_err},
                  {vecs[i].e_ovs, vecs[i].e_mid, vecs[i].e_bit, vecs[i].e_cnt, vecs[i].e_err});
        end

        // Resync mid-interval: D=10, cnt=6, ovs_cnt=5.
        step(1'b1, 1'b1, 16'd10, 4'd0, 1'b0);
        for (int i = 0; i < 56; i++) step(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
        check("pre-sync ovs_cnt", 64'(ovs_cnt), 64'd5);
        step(1'b1, 1'b0, 16'd0, 4'd0, 1'b1);
        first_tick = -1; tick_cnt_val = -1; mid_at = -1;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
            if (ovs_tick && first_tick < 0) begin first_tick = i; tick_cnt_val = int'(ovs_cnt); end
            if (mid_tick && mid_at < 0) mid_at = i;
        end
        check("sync first tick edge", 64'(first_tick), 64'd10);
        check("sync first tick ovs_cnt", 64'(tick_cnt_val), 64'd1);
        check("sync mid_tick edge", 64'(mid_at), 64'd80);

        // Enable held low for 7 cycles mid-interval stretches it by 7.
        step(1'b1, 1'b1, 16'd10, 4'd0, 1'b0);
        tick_at = -1;
        for (int i = 1; i <= 40; i++) begin
            step((i >= 6 && i <= 12) ? 1'b0 : 1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
            if (ovs_tick && tick_at < 0) tick_at = i;
        end
        check("enable-stall tick edge", 64'(tick_at), 64'd17);

        // Randomized traffic against the model.
        step(1'b1, 1'b1, 16'd5, 4'd7, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 149) == 0),
                 16'($urandom_range(0, 12)), 4'($urandom), ($urandom_range(0, 199) == 0));
        end

        // Asynchronous reset while a tick is high and cfg_err is set.
        step(1'b1, 1'b1, 16'd3, 4'd0, 1'b0);
        step(1'b1, 1'b1, 16'd1, 4'd0, 1'b0);
        tick_at = -1;
        for (int i = 0; i < 20 && tick_at < 0; i++) begin
            step(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
            if (ovs_tick) tick_at = i;
        end
        check("pre-reset tick seen", 64'(tick_at >= 0), 64'd1);
        check("pre-reset cfg_err", 64'(cfg_err), 64'd1);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("async reset outputs", {ovs_tick, mid_tick, bit_tick, ovs_cnt, cfg_err}, 64'd0);
        @(posedge clk); #3 reset_n = 1'b1;

        default_timing("post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
